// File: rtl/switch_debouncer_pkg.sv
// Shared defaults for the switch sensing front end: channel count, reset level and
// debounce timing, plus the counter-width helper used by every channel.
package switch_pkg;

    localparam int   N_SW_DEF           = 20;
    localparam int   SYNC_STAGES_DEF    = 2;
    localparam int   DEBOUNCE_TICKS_DEF = 4;
    localparam logic RESET_LEVEL_DEF    = 1'b1;

    // Wide enough to hold DEBOUNCE_TICKS-1 even when DEBOUNCE_TICKS is a power of two.
    function automatic int cnt_width(input int ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Bundle of switch inputs and conditioned outputs between the sensing front end and its
// consumers; master drives raw levels and the tick, slave is the debouncer.
interface switch_debouncer_if
    import switch_pkg::*;
#(
    parameter int N_SW = N_SW_DEF
);

    logic            tick_en;
    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_stable;
    logic [N_SW-1:0] rise_pulse;
    logic [N_SW-1:0] fall_pulse;
    logic            any_change;
    logic            all_closed;

    modport master (
        output tick_en,
        output sw_raw,
        input  sw_stable,
        input  rise_pulse,
        input  fall_pulse,
        input  any_change,
        input  all_closed
    );

    modport slave (
        input  tick_en,
        input  sw_raw,
        output sw_stable,
        output rise_pulse,
        output fall_pulse,
        output any_change,
        output all_closed
    );

endinterface

// File: rtl/switch_debouncer_channel.sv
// One switch channel: synchroniser chain, tick-qualified disagreement counter, stable level
// flop and registered edge pulses that change on the same edge as the stable level.
module debounce_channel
    import switch_pkg::*;
#(
    parameter int   SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter logic RESET_LEVEL    = RESET_LEVEL_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_en,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int             CW   = cnt_width(DEBOUNCE_TICKS);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic [CW-1:0]          cnt_p1;
    logic                   s_p0;
    logic                   accept;

    assign s_p0   = sync_p0[SYNC_STAGES-1];
    assign accept = (s_p0 != stable) && tick_en && (cnt_p1 == LAST);

    // Stage p0: synchroniser; stage p1: counter, stable level and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= {SYNC_STAGES{RESET_LEVEL}};
            stable  <= RESET_LEVEL;
            cnt_p1  <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
            rise    <= accept & s_p0;
            fall    <= accept & ~s_p0;
            // Any cycle of agreement throws away partial progress, tick or not.
            if (s_p0 == stable) begin
                cnt_p1 <= '0;
            end else if (tick_en) begin
                if (cnt_p1 == LAST) begin
                    stable <= s_p0;
                    cnt_p1 <= '0;
                end else begin
                    cnt_p1 <= cnt_p1 + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces N_SW asynchronous switch levels and reduces the per-channel results into a
// single change strobe and an all-closed flag for the downstream AND/LED logic.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int   N_SW           = N_SW_DEF,
    parameter int   SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter logic RESET_LEVEL    = RESET_LEVEL_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    switch_debouncer_if.slave   bus
);

    logic [N_SW-1:0] stable_w;
    logic [N_SW-1:0] rise_w;
    logic [N_SW-1:0] fall_w;

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .RESET_LEVEL    (RESET_LEVEL)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick_en (bus.tick_en),
            .raw     (bus.sw_raw[i]),
            .stable  (stable_w[i]),
            .rise    (rise_w[i]),
            .fall    (fall_w[i])
        );
    end

    // Reductions come straight off channel flops so consumers see glitch-free sources.
    assign bus.sw_stable  = stable_w;
    assign bus.rise_pulse = rise_w;
    assign bus.fall_pulse = fall_w;
    assign bus.any_change = |(rise_w | fall_w);
    assign bus.all_closed = &stable_w;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer at default parameters (20 channels, 2 sync stages,
// 4 debounce ticks, reset level high).
module tb_switch_debouncer;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    switch_debouncer_if bus ();

    switch_debouncer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Advance one rising edge and land 1ns after it for sampling/driving.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   first_acc;
        int   first_fall;
        logic seen;

        n_chk       = 0;
        n_pass      = 0;
        rst_n       = 1'b1;
        bus.tick_en = 1'b1;
        bus.sw_raw  = 20'hFFFFF;

        // 1: reset state
        #2 rst_n = 1'b0;
        #20;
        chk("rst_stable",     32'(bus.sw_stable),  32'hFFFFF);
        chk("rst_all_closed", 32'(bus.all_closed), 32'h1);
        chk("rst_rise",       32'(bus.rise_pulse), 32'h0);
        chk("rst_fall",       32'(bus.fall_pulse), 32'h0);
        chk("rst_any",        32'(bus.any_change), 32'h0);
        step(1);
        rst_n = 1'b1;
        step(3);

        // 2: clean fall on ch3, accepted on the 6th edge
        bus.sw_raw[3] = 1'b0;
        step(5);
        chk("t2_early_stable", 32'(bus.sw_stable), 32'hFFFFF);
        chk("t2_early_any",    32'(bus.any_change), 32'h0);
        step(1);
        chk("t2_stable",     32'(bus.sw_stable),  32'hFFFF7);
        chk("t2_fall",       32'(bus.fall_pulse), 32'h00008);
        chk("t2_rise",       32'(bus.rise_pulse), 32'h0);
        chk("t2_any",        32'(bus.any_change), 32'h1);
        chk("t2_all_closed", 32'(bus.all_closed), 32'h0);
        step(1);
        chk("t2_fall_end", 32'(bus.fall_pulse), 32'h0);
        chk("t2_any_end",  32'(bus.any_change), 32'h0);
        bus.sw_raw[3] = 1'b1;
        step(5);
        chk("t2_rel_early", 32'(bus.sw_stable), 32'hFFFF7);
        step(1);
        chk("t2_rel_rise",   32'(bus.rise_pulse), 32'h00008);
        chk("t2_rel_closed", 32'(bus.all_closed), 32'h1);
        step(1);

        // 3: bounce on ch5 is discarded, then a held low is accepted
        bus.sw_raw[5] = 1'b0;
        step(3);
        bus.sw_raw[5] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            seen = seen | bus.any_change;
        end
        chk("t3_bounce_any",    32'(seen),          32'h0);
        chk("t3_bounce_stable", 32'(bus.sw_stable), 32'hFFFFF);
        bus.sw_raw[5] = 1'b0;
        step(5);
        chk("t3_hold_early", 32'(bus.sw_stable), 32'hFFFFF);
        step(1);
        chk("t3_hold_fall",   32'(bus.fall_pulse), 32'h00020);
        chk("t3_hold_stable", 32'(bus.sw_stable),  32'hFFFDF);
        step(4);
        bus.sw_raw[5] = 1'b1;
        step(7);
        chk("t3_restore", 32'(bus.sw_stable), 32'hFFFFF);

        // 4: sparse ticks on ch0; ticks on edges 4,8,12,16 -> accept on edge 16
        first_acc  = 0;
        first_fall = 0;
        bus.sw_raw[0] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            bus.tick_en = (e % 4 == 0);
            step(1);
            if (bus.sw_stable[0] == 1'b0 && first_acc == 0) first_acc = e;
            if (bus.fall_pulse[0] && first_fall == 0) first_fall = e;
        end
        bus.tick_en = 1'b1;
        chk("t4_accept_edge", 32'(first_acc),  32'd16);
        chk("t4_fall_edge",   32'(first_fall), 32'd16);

        // 5: ch0 and ch19 released together
        bus.sw_raw[19] = 1'b0;
        step(7);
        chk("t5_both_low", 32'(bus.sw_stable), 32'h7FFFE);
        bus.sw_raw[0]  = 1'b1;
        bus.sw_raw[19] = 1'b1;
        step(5);
        chk("t5_early", 32'(bus.sw_stable), 32'h7FFFE);
        step(1);
        chk("t5_rise",       32'(bus.rise_pulse), 32'h80001);
        chk("t5_any",        32'(bus.any_change), 32'h1);
        chk("t5_all_closed", 32'(bus.all_closed), 32'h1);
        step(1);
        chk("t5_any_end", 32'(bus.any_change), 32'h0);

        // 6: reset while ch7 has cnt=2; full run needed after release
        bus.sw_raw[7] = 1'b0;
        step(4);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_stable", 32'(bus.sw_stable), 32'hFFFFF);
        step(1);
        #2 rst_n = 1'b1;
        step(5);
        chk("t6_early", 32'(bus.sw_stable), 32'hFFFFF);
        step(1);
        chk("t6_stable", 32'(bus.sw_stable),  32'hFFF7F);
        chk("t6_fall",   32'(bus.fall_pulse), 32'h00080);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
